rv32i_prefetch_unit: RTL and testbench
======================================

Name: rv32i_prefetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the single-entry PC→INSTRUCTION handshake in the multi-cycle core.
- Runs ahead sequentially (pc+4) with up to MAX_OUTSTANDING requests in flight to the memory arbiter's fetch port.
- Buffers returned words in a FIFO_DEPTH-entry prefetch queue and presents {instr, pc, err} on a valid/ready channel to decode.
- Supports redirect (branch/jump/trap) with flush and discard of stale in-flight responses, plus a stall input.

Parameters:
- DATA_WIDTH, 32, address/instruction width.
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; 1..FIFO_DEPTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- stall  in  1  when high, no new request is raised; outstanding/output traffic continues.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  DATA_WIDTH  new fetch address; bits [1:0] ignored (treated as 0).
- req_valid  out  1  fetch request to arbiter.
- req_ready  in  1  arbiter accepts request.
- req_addr  out  DATA_WIDTH  word-aligned fetch address.
- rsp_valid  in  1  fetch response valid; responses return in request order.
- rsp_ready  out  1  always 1 (queue space is reserved at issue).
- rsp_data  in  DATA_WIDTH  instruction word.
- rsp_err  in  1  bus error on this fetch.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  DATA_WIDTH  head instruction word.
- instr_pc  out  DATA_WIDTH  address of head instruction.
- instr_err  out  1  head carries a fetch error.

Behaviour:
- Reset (async, RST=1): fetch_pc=BOOT_ADDR, req_valid=0, req_addr=BOOT_ADDR, queue empty, instr_valid=0, instr/instr_pc=0, instr_err=0, outstanding=0, discard=0. rsp_ready=1 at all times.
- Credit: req_valid may rise only when !stall && !redirect_valid && outstanding + queue_count + (req_valid) < FIFO_DEPTH && outstanding < MAX_OUTSTANDING. Registered; first request in the cycle after RST falls.
- Request rule (AXI-style): once req_valid=1, req_valid and req_addr stay stable until req_ready; stall and redirect never retract a pending request. On handshake: outstanding+1, fetch_pc+=4 (wraps modulo 2^DATA_WIDTH), next request may assert the following cycle (back-to-back allowed if credit).
- Response: on rsp_valid, outstanding-1. If discard>0: drop the word, discard-1. Else push {rsp_data, pc_tag, rsp_err}, where pc_tag comes from an in-order tag queue of issued addresses (depth MAX_OUTSTANDING). Pushed entry is visible on instr_* the next cycle (one-cycle minimum rsp→instr latency; two cycles from req handshake with zero-wait memory).
- Output: instr_valid = queue non-empty; pop on instr_valid && instr_ready. Push and pop in the same cycle are both honoured; count unchanged.
- Redirect (redirect_valid=1): queue cleared (any same-cycle pop or push is void); discard = outstanding after this cycle's events, plus 1 if a request is pending or handshaking this cycle; fetch_pc = {redirect_pc[DW-1:2],2'b00}. A same-cycle response is dropped. The next request to the new address asserts no earlier than the cycle after redirect. Back-to-back redirects: the latest wins, and discard accumulates correctly.
- Error: rsp_err entries are delivered in order with instr_err=1; fetching continues sequentially (the core decides on trap/redirect).
- Overflow is impossible by credit rule; a response with outstanding=0 is a protocol violation (assertion, ignored).
- Reset mid-operation: all state returns to reset values immediately; responses to pre-reset requests are the arbiter's responsibility (it is reset on the same RST).

Test Plan:
- Reset release, zero-wait memory, instr_ready=1 → requests 0x0,0x4,0x8… back-to-back; instr_valid at cycle 3 with instr_pc=0x0, then one instruction per cycle.
- instr_ready=0, memory always ready → exactly 4 (FIFO_DEPTH) words fetched, req_valid stays 0, no rsp dropped; release → 0x0..0xC delivered in order, then fetching resumes at 0x10.
- Memory latency 5 cycles, two requests (0x0,0x4) outstanding, redirect to 0x103 → both stale responses dropped; next delivered instr_pc=0x100.
- req_valid=1 with req_ready=0 while stall rises → req_valid/req_addr held until accepted; no further request until stall=0.
- rsp_err=1 on fetch of 0x8 → entries 0x0, 0x4 with err=0; 0x8 with err=1; 0xC fetched normally.
- RST pulse during outstanding fetch → next cycle req_valid=0, instr_valid=0; after release first req_addr=BOOT_ADDR.

Source files
------------

// File: rtl/rv32i_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_prefetch_unit
// Purpose  : Sequential instruction prefetcher. Issues word-aligned fetch
//            requests ahead of decode, keeps up to MAX_OUTSTANDING of them in
//            flight, buffers returned words in a FIFO_DEPTH-entry queue and
//            presents {instr, instr_pc, instr_err} on a valid/ready channel.
//            A redirect flushes the queue and discards responses that are
//            still owed for requests issued before it.
// Ports    : CLK, RST                  - clock, async active-high reset
//            stall                     - suppress new requests
//            redirect_valid/_pc        - restart fetch at a new address
//            req_valid/_ready/_addr    - fetch request to the arbiter
//            rsp_valid/_ready/_data/_err - in-order fetch responses
//            instr_valid/_ready        - decode handshake
//            instr, instr_pc, instr_err - queue head
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_prefetch_unit #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR       = '0,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_err
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_sum_w = c_cnt_w + 1;
  localparam int c_tag_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [c_sum_w-1:0] c_depth    = c_sum_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_max_out  = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_tag_w-1:0] c_tag_last = c_tag_w'(MAX_OUTSTANDING - 1);

  // r_fetch_pc is the address the *next raised* request will carry; it
  // advances when a request is raised so a request left pending across a
  // redirect keeps its own address while the new stream starts cleanly.
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_req_valid;
  logic [DATA_WIDTH-1:0] r_req_addr;
  logic [c_cnt_w-1:0]    r_outstanding;
  logic [c_cnt_w-1:0]    r_discard;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;

  logic [DATA_WIDTH-1:0] r_q_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_pc    [FIFO_DEPTH];
  logic                  r_q_err   [FIFO_DEPTH];

  // Addresses of accepted requests, in issue order, to tag responses.
  logic [DATA_WIDTH-1:0] r_tag [MAX_OUTSTANDING];
  logic [c_tag_w-1:0]    r_tag_wr;
  logic [c_tag_w-1:0]    r_tag_rd;

  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_raise;
  logic [c_cnt_w-1:0]    w_out_nxt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic [c_cnt_w-1:0]    w_disc_redirect;
  logic [DATA_WIDTH-1:0] w_redirect_pc;

  assign w_req_fire = r_req_valid & req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign w_rsp_fire = rsp_valid & (r_outstanding != '0);
  assign w_push     = w_rsp_fire & (r_discard == '0) & ~redirect_valid;
  assign w_pop      = (r_count != '0) & instr_ready & ~redirect_valid;

  assign w_out_nxt  = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_fire);
  assign w_cnt_nxt  = redirect_valid ? '0
                    : r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  // Every response still owed for a pre-redirect request must be dropped:
  // those already in flight (less one answered now) plus a request that is
  // pending or being accepted this cycle. Old discards are a subset of the
  // in-flight count, so the new value replaces rather than adds.
  assign w_disc_redirect = r_outstanding - c_cnt_w'(w_rsp_fire) + c_cnt_w'(r_req_valid);

  // Queue space is reserved at issue: a new request needs one free slot
  // beyond everything already queued or in flight after this edge.
  assign w_credit = ((c_sum_w'(w_out_nxt) + c_sum_w'(w_cnt_nxt)) < c_depth) &&
                    (w_out_nxt < c_max_out);
  assign w_raise  = ~stall & ~redirect_valid & w_credit;

  assign w_redirect_pc = redirect_pc & ~DATA_WIDTH'(3);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_pc    <= BOOT_ADDR;
      r_req_valid   <= 1'b0;
      r_req_addr    <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
        r_q_err[i]   <= 1'b0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_outstanding <= w_out_nxt;
      r_count       <= w_cnt_nxt;

      // A raised request is held stable until accepted.
      if (!r_req_valid || req_ready) begin
        r_req_valid <= w_raise;
        if (w_raise) begin
          r_req_addr <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
        end
      end
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
      end

      if (w_req_fire) begin
        r_tag[r_tag_wr] <= r_req_addr;
        r_tag_wr        <= (r_tag_wr == c_tag_last) ? '0 : r_tag_wr + c_tag_w'(1);
      end
      if (w_rsp_fire) begin
        r_tag_rd <= (r_tag_rd == c_tag_last) ? '0 : r_tag_rd + c_tag_w'(1);
      end

      if (redirect_valid) begin
        r_discard <= w_disc_redirect;
      end else if (w_rsp_fire && (r_discard != '0)) begin
        r_discard <= r_discard - c_cnt_w'(1);
      end

      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_q_instr[r_wr_ptr] <= rsp_data;
          r_q_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
          r_q_err[r_wr_ptr]   <= rsp_err;
          r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (!RST && rsp_valid) begin
      a_rsp_has_request: assert (r_outstanding != '0);
    end
  end

  assign req_valid   = r_req_valid;
  assign req_addr    = r_req_addr;
  assign rsp_ready   = 1'b1;
  assign instr_valid = (r_count != '0);
  assign instr       = r_q_instr[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];
  assign instr_err   = r_q_err[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_prefetch_unit
// Purpose  : Self-checking bench for rv32i_prefetch_unit. A behavioural
//            in-order memory with configurable latency answers fetches;
//            non-stale responses push the expected {instr, pc, err} into a
//            scoreboard that is popped as decode accepts instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_prefetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;

  always #5 clk = ~clk;

  rv32i_prefetch_unit #(
    .DATA_WIDTH      (32),
    .BOOT_ADDR       (BOOT),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
    int          due;
  } pipe_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  pipe_t       pipe[$];
  exp_t        sb[$];
  int          cyc, n_checks, n_fail, n_hs, n_deliv, n_err_deliv, lat;
  logic [31:0] exp_req_addr, stale_addr, last_hs_addr, err_addr;
  logic        stale_pending;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: account for what happens at the coming edge, advance, then
  // drive the memory response for the next edge.
  task automatic step();
    pipe_t p;
    exp_t  e;
    if (!rst) begin
      if (req_valid && req_ready) begin
        n_hs++;
        last_hs_addr = req_addr;
        p.addr = req_addr;
        p.due  = cyc + lat;
        if (stale_pending) begin
          check("req_addr_stale", req_addr, stale_addr);
          p.stale       = 1'b1;
          stale_pending = 1'b0;
        end else begin
          check("req_addr", req_addr, exp_req_addr);
          exp_req_addr = exp_req_addr + 32'd4;
          p.stale      = redirect_valid;
        end
        pipe.push_back(p);
      end else if (redirect_valid && req_valid && !stale_pending) begin
        stale_pending = 1'b1;
        stale_addr    = exp_req_addr;
      end
      if (rsp_valid) begin
        p = pipe.pop_front();
        if (!p.stale && !redirect_valid) begin
          e.data = mem_word(p.addr);
          e.pc   = p.addr;
          e.err  = (p.addr == err_addr);
          sb.push_back(e);
        end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        n_deliv++;
        if (instr_err) n_err_deliv++;
        if (sb.size() == 0) begin
          check("sb_depth_at_pop", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.data);
          check("instr_err", 32'(instr_err), 32'(e.err));
        end
      end
      if (redirect_valid) begin
        foreach (pipe[i]) pipe[i].stale = 1'b1;
        sb.delete();
        exp_req_addr = redirect_pc & ~32'h3;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (pipe.size() != 0 && pipe[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pipe[0].addr);
      rsp_err   = (pipe[0].addr == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
    end
  endtask

  task automatic clear_model();
    pipe.delete();
    sb.delete();
    stale_pending = 1'b0;
    exp_req_addr  = BOOT;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    rsp_err       = 1'b0;
    n_hs          = 0;
    n_deliv       = 0;
    n_err_deliv   = 0;
  endtask

  task automatic apply_reset(input bit do_checks);
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    req_ready      = 1'b1;
    instr_ready    = 1'b1;
    lat            = 1;
    err_addr       = 32'hFFFF_FFFF;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    if (do_checks) begin
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_req_addr", req_addr, BOOT);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_instr_err", 32'(instr_err), 32'd0);
      check("rst_rsp_ready", 32'(rsp_ready), 32'd1);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic drain();
    bit idle;
    stall       = 1'b1;
    instr_ready = 1'b1;
    req_ready   = 1'b1;
    idle        = 1'b0;
    for (int g = 0; g < 100; g++) begin
      if (pipe.size() == 0 && !req_valid && !instr_valid && !rsp_valid) begin
        idle = 1'b1;
        break;
      end
      step();
    end
    check("drain_idle", 32'(idle), 32'd1);
    check("sb_leftover", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int g;
    n_checks = 0;
    n_fail   = 0;

    // 1: reset values, first fetch latency, back-to-back delivery
    apply_reset(1'b1);
    check("t1_req_valid_c0", 32'(req_valid), 32'd0);
    step();
    check("t1_req_valid_c1", 32'(req_valid), 32'd1);
    check("t1_req_addr_c1", req_addr, BOOT);
    g = 0;
    while (!instr_valid && g < 20) begin step(); g++; end
    check("t1_first_valid_cycle", 32'(cyc), 32'd3);
    check("t1_first_pc", instr_pc, BOOT);
    nv = 0;
    repeat (8) begin
      if (instr_valid) nv++;
      step();
    end
    check("t1_one_per_cycle", 32'(nv), 32'd8);
    drain();

    // 2: decode blocked, queue fills to FIFO_DEPTH, then resumes at 0x10
    apply_reset(1'b0);
    instr_ready = 1'b0;
    repeat (12) step();
    check("t2_fetched", 32'(n_hs), 32'd4);
    check("t2_req_idle", 32'(req_valid), 32'd0);
    check("t2_instr_valid", 32'(instr_valid), 32'd1);
    check("t2_queued", 32'(sb.size()), 32'd4);
    instr_ready = 1'b1;
    g = 0;
    while (n_hs < 5 && g < 20) begin step(); g++; end
    check("t2_resume_addr", last_hs_addr, 32'h10);
    drain();
    check("t2_delivered", 32'(n_deliv >= 4), 32'd1);

    // 3: redirect with two slow fetches in flight
    apply_reset(1'b0);
    lat = 5;
    repeat (3) step();
    check("t3_in_flight", 32'(n_hs), 32'd2);
    check("t3_no_credit", 32'(req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    g = 0;
    while (!instr_valid && g < 40) begin step(); g++; end
    check("t3_no_stale", 32'(n_deliv), 32'd0);
    check("t3_first_pc", instr_pc, 32'h100);
    drain();

    // 4: pending request survives stall; nothing new while stalled
    apply_reset(1'b0);
    req_ready = 1'b0;
    step();
    check("t4_req_up", 32'(req_valid), 32'd1);
    stall = 1'b1;
    repeat (3) begin
      step();
      check("t4_held_valid", 32'(req_valid), 32'd1);
      check("t4_held_addr", req_addr, BOOT);
    end
    req_ready = 1'b1;
    step();
    repeat (3) begin
      check("t4_stalled", 32'(req_valid), 32'd0);
      step();
    end
    stall = 1'b0;
    g = 0;
    while (!req_valid && g < 5) begin step(); g++; end
    check("t4_resume_addr", req_addr, 32'h4);
    drain();

    // 5: bus error on 0x8 is delivered in order, fetching continues
    apply_reset(1'b0);
    err_addr = 32'h8;
    repeat (14) step();
    check("t5_err_count", 32'(n_err_deliv), 32'd1);
    check("t5_past_err", 32'(n_deliv >= 4), 32'd1);
    drain();

    // 6: asynchronous reset during outstanding fetches
    apply_reset(1'b0);
    lat = 5;
    repeat (3) step();
    check("t6_in_flight", 32'(n_hs), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("t6_async_req_valid", 32'(req_valid), 32'd0);
    check("t6_async_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_async_req_addr", req_addr, BOOT);
    clear_model();
    lat = 1;
    @(posedge clk);
    #1;
    check("t6_rst_edge_req_valid", 32'(req_valid), 32'd0);
    rst = 1'b0;
    cyc = 0;
    g = 0;
    while (n_hs == 0 && g < 10) begin step(); g++; end
    check("t6_first_addr", last_hs_addr, BOOT);
    drain();

    // 7: back-to-back redirects while responses are arriving
    apply_reset(1'b0);
    lat = 3;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    g = 0;
    while (!instr_valid && g < 40) begin step(); g++; end
    check("t7_first_pc", instr_pc, 32'h80);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
